// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt scheduler: FSM states,
// default handler vectors and the source-index width helper.
package int_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [31:0] DEF_VEC0 = 32'h0000_0009;
  localparam logic [31:0] DEF_VEC1 = 32'h0000_0020;
  localparam logic [31:0] DEF_VEC2 = 32'h0000_0020;
  localparam logic [31:0] DEF_VEC3 = 32'h0000_0009;

  // Index width for n sources; never below one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Combinational fixed-priority encoder: lowest set bit wins, with a valid flag.
module int_prio_enc
  import int_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = id_width(N)
) (
  input  logic [N-1:0]   req,
  output logic           valid,
  output logic [IDW-1:0] idx
);

  // Walk from the top down so the lowest asserted index is the last writer.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/int_sched.sv
// Interrupt scheduler in front of fetch: latch, mask, prioritise, hand off one
// request and block until rti. INT_SCHED_EDGE_EN selects rising-edge irq capture.
module int_sched
  import int_pkg::*;
#(
  parameter int          NUM_SRC = 4,
  parameter logic [31:0] VEC0    = DEF_VEC0,
  parameter logic [31:0] VEC1    = DEF_VEC1,
  parameter logic [31:0] VEC2    = DEF_VEC2,
  parameter logic [31:0] VEC3    = DEF_VEC3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRC-1:0]          irq,
  input  logic                        mask_we,
  input  logic [NUM_SRC-1:0]          mask_wdata,
  input  logic                        stall,
  input  logic                        br_stall,
  input  logic                        int_ack,
  input  logic                        rti,
  output logic                        int_req,
  output logic [31:0]                 int_vector,
  output logic [id_width(NUM_SRC)-1:0] int_id,
  output logic                        in_service,
  output logic [NUM_SRC-1:0]          pending,
  output logic [NUM_SRC-1:0]          mask
);

  localparam int IDW = id_width(NUM_SRC);

  state_t             state_reg;
  logic               int_req_reg;
  logic [31:0]        int_vector_reg;
  logic [IDW-1:0]     int_id_reg;
  logic               in_service_reg;
  logic [NUM_SRC-1:0] pending_reg;
  logic [NUM_SRC-1:0] pending_next;
  logic [NUM_SRC-1:0] mask_reg;
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clr_vec;
  logic [NUM_SRC-1:0] eligible;
  logic               sel_valid;
  logic [IDW-1:0]     sel_idx;
  logic [31:0]        vec_tab [NUM_SRC];

`ifdef INT_SCHED_EDGE_EN
  logic [NUM_SRC-1:0] irq_d_reg;
  logic [NUM_SRC-1:0] edge_reg;

  // The rise is registered, costing one extra cycle before pending sets.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_d_reg <= '0;
      edge_reg  <= '0;
    end else begin
      irq_d_reg <= irq;
      edge_reg  <= irq & ~irq_d_reg;
    end
  end

  assign set_vec = edge_reg;
`else
  assign set_vec = irq;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign vec_tab[gi] = (gi == 0) ? VEC0 :
                           (gi == 1) ? VEC1 :
                           (gi == 2) ? VEC2 : VEC3;
      assign clr_vec[gi] = (state_reg == REQ) && int_ack && (int_id_reg == IDW'(gi));
    end
  endgenerate

  // A fresh set in the acknowledge cycle outranks the clear.
  assign pending_next = (pending_reg & ~clr_vec) | set_vec;
  assign eligible     = pending_reg & ~mask_reg;

  int_prio_enc #(
    .N   (NUM_SRC),
    .IDW (IDW)
  ) u_prio_enc (
    .req   (eligible),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= '0;
      mask_reg    <= '0;
    end else begin
      pending_reg <= pending_next;
      if (mask_we) begin
        mask_reg <= mask_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      int_req_reg    <= 1'b0;
      int_vector_reg <= VEC0;
      int_id_reg     <= '0;
      in_service_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sel_valid && !stall && !br_stall) begin
            state_reg      <= REQ;
            int_req_reg    <= 1'b1;
            int_id_reg     <= sel_idx;
            int_vector_reg <= vec_tab[sel_idx];
          end
        end
        // Request stays up regardless of stalls or mask changes until taken.
        REQ: begin
          if (int_ack) begin
            state_reg      <= SERVICE;
            int_req_reg    <= 1'b0;
            in_service_reg <= 1'b1;
          end
        end
        SERVICE: begin
          if (rti) begin
            state_reg      <= IDLE;
            in_service_reg <= 1'b0;
          end
        end
        default: begin
          state_reg      <= IDLE;
          int_req_reg    <= 1'b0;
          in_service_reg <= 1'b0;
        end
      endcase
    end
  end

  assign int_req    = int_req_reg;
  assign int_vector = int_vector_reg;
  assign int_id     = int_id_reg;
  assign in_service = in_service_reg;
  assign pending    = pending_reg;
  assign mask       = mask_reg;

endmodule

// File: doc/int_sched.md
Name: int_sched

Overview:
- Interrupt scheduler that sits in front of the fetch stage.
- Latches up to NUM_SRC interrupt lines and applies a per-source mask.
- Picks one source by fixed priority and presents a single request with its vector address to fetch.
- Holds that request until fetch acknowledges the PC redirect, then blocks further requests until the handler returns (rti).

Parameters:
- NUM_SRC, 4, number of interrupt sources (2..8).
- VEC0, 32'h00000009, handler address for source 0.
- VEC1, 32'h00000020, handler address for source 1.
- VEC2, 32'h00000020, handler address for source 2.
- VEC3, 32'h00000009, handler address for source 3 (sources above 3 also use VEC3).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- irq  in  NUM_SRC  raw interrupt lines
- mask_we  in  1  write strobe for the mask register
- mask_wdata  in  NUM_SRC  new mask value; 1 = source masked
- stall  in  1  pipeline stall; no new selection while high
- br_stall  in  1  branch stall; no new selection while high
- int_ack  in  1  one-cycle pulse from fetch: PC has been loaded with int_vector
- rti  in  1  return-from-interrupt retired
- int_req  out  1  interrupt request to fetch
- int_vector  out  32  handler address of the selected source
- int_id  out  $clog2(NUM_SRC)  index of the selected or in-service source
- in_service  out  1  a handler is running
- pending  out  NUM_SRC  latched, not-yet-acknowledged requests
- mask  out  NUM_SRC  current mask register

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high. Reset has priority over all other inputs.
- Reset values: pending=0, mask=0 (all sources enabled), state=IDLE, int_req=0, int_vector=VEC0, int_id=0, in_service=0.
- Pending latch: pending[i] sets on any cycle with irq[i]=1 (level-sensitive, sticky). It clears only on int_ack for int_id. If set and clear hit the same bit in the same cycle, set wins.
- Mask: when mask_we=1, mask <= mask_wdata on the next edge. Masked sources still latch into pending but cannot be selected.
- Eligible set: pending & ~mask. Fixed priority: the lowest index wins.
- IDLE state:
  - Advance to REQ when the eligible set is nonzero and stall=0 and br_stall=0.
  - On that edge, int_id and int_vector are registered from the winning source.
- REQ state:
  - int_req=1; int_id and int_vector are frozen.
  - stall, br_stall and mask writes do not withdraw the request.
  - On int_ack: clear pending[int_id], go to SERVICE, set in_service=1.
- SERVICE state:
  - int_req=0; no selection takes place (no nesting); int_id holds the in-service source.
  - On rti: go to IDLE and clear in_service.
  - A new selection may occur on the cycle after returning to IDLE.
- Ignored inputs: rti in IDLE or REQ, and int_ack outside REQ.
- Latency: irq[i] rising at edge N gives pending[i]=1 after edge N. With no stalls, int_req=1 after edge N+1 (2 cycles). int_ack at edge M gives in_service=1 and int_req=0 after edge M.
- Reset in REQ or SERVICE: return to IDLE with all state cleared, including the mask.

Optional Feature:
- Macro: INT_SCHED_EDGE_EN.
- Defined: each irq line passes through a registered rising-edge detector. pending[i] sets only on a 0->1 transition of irq[i]; a line held high does not re-latch after its ack. This adds one cycle of latency (3 total). The detector register resets to 0, so a line already high out of reset latches on the first cycle after reset.
- Undefined: level-sensitive latching as described above.

Decomposition:
- Shared package int_pkg holds:
  - the state enum (IDLE, REQ, SERVICE);
  - the default vector constants;
  - an id-width helper function.
- One sub-module, int_prio_enc: a combinational fixed-priority encoder (NUM_SRC bits in; valid flag and index out). It is instantiated once for the eligible-set selection.

Test Plan:
- Single source: pulse irq[2] for 1 cycle → int_req=1 two cycles later with int_id=2 and int_vector=32'h20. int_ack → pending=0, in_service=1. rti → IDLE; int_req stays 0.
- Priority: assert irq[3] and irq[1] in the same cycle → first request int_id=1 / 32'h20. After ack and rti, second request int_id=3 / 32'h09.
- Masking and stall:
  - mask=4'b0001, then irq[0] → pending[0]=1 but int_req stays 0. Write mask=0 → request follows after the select edge.
  - Holding stall=1 in IDLE delays selection; stall raised in REQ leaves int_req=1.
- No nesting: in SERVICE with int_id=1, assert irq[0] → pending[0]=1 and int_req=0 until rti. Request for source 0 follows 1 cycle after rti.
- Set/clear collision: irq[2] held high across int_ack for id 2 → pending[2] stays 1; with the macro undefined, re-request after rti.
- Reset mid-operation: reset asserted in REQ → next cycle int_req=0, pending=0, in_service=0, int_vector=32'h09.
